mode_scheduler: RTL and testbench

- Arbitrates the shared debounced buttons (btnU trigger, btnR split) between the stopwatch control unit (Ctl) and the Stash memory unit.
- Adds an auto-scroll playback mode for Stash and an idle timeout that returns control to the stopwatch.
- Sits between the Debouncer outputs and the Ctl/Stash inputs in the Stopwatch top level.
- Replaces the top-level selected_mode register and its routing assigns.

---
 rtl/mode_scheduler_pkg.sv | 46 ++++
 rtl/mode_scheduler_interval_timer.sv | 25 ++
 rtl/mode_scheduler.sv | 152 +++++++++++++++
 tb/tb_mode_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mode_scheduler_pkg.sv
// Shared encodings for the stopwatch mode scheduler: mode states, LED patterns
// and the registered output bundle.
package mode_scheduler_pkg;

    typedef enum logic [1:0] {
        SW         = 2'd0,
        STASH_MAN  = 2'd1,
        STASH_AUTO = 2'd2
    } mode_t;

    localparam int unsigned LED_W = 3;

    localparam logic [LED_W-1:0] LED_ON       = 3'b111;
    localparam logic [LED_W-1:0] LED_OFF      = 3'b000;
    localparam logic [LED_W-1:0] SCROLL_FIRST = 3'b001;

    typedef struct packed {
        logic             ctl_trig;
        logic             ctl_split;
        logic             stash_next;
        logic             stash_valid;
        logic             sw_selected;
        logic [LED_W-1:0] led_left;
        logic [LED_W-1:0] led_right;
    } sched_out_t;

    localparam sched_out_t OUT_RESET = '{
        ctl_trig:    1'b0,
        ctl_split:   1'b0,
        stash_next:  1'b0,
        stash_valid: 1'b0,
        sw_selected: 1'b1,
        led_left:    LED_ON,
        led_right:   LED_OFF
    };

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // One-hot scroll indicator rotates left: 001 -> 010 -> 100 -> 001.
    function automatic logic [LED_W-1:0] rotl_led(input logic [LED_W-1:0] v);
        return {v[LED_W-2:0], v[LED_W-1]};
    endfunction

endpackage

// File: rtl/mode_scheduler_interval_timer.sv
// Cycle counter that raises expired while enabled and sitting at limit; it
// wraps to zero on expiry so periodic events need no extra clear.
module interval_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count;

    assign expired = enable && (count == limit);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= expired ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/mode_scheduler.sv
// Routes the shared debounced buttons to either the stopwatch control or the
// stash unit, with auto-scroll playback and an idle return to stopwatch mode.
module mode_scheduler
    import mode_scheduler_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned TIMEOUT_S = 10,
    parameter int unsigned SCROLL_S  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             toggle,
    input  logic             trig,
    input  logic             split,
    input  logic             sample,
    output logic             ctl_trig,
    output logic             ctl_split,
    output logic             stash_next,
    output logic             stash_valid,
    output logic             sw_selected,
    output logic [LED_W-1:0] led_left,
    output logic [LED_W-1:0] led_right
);

    localparam int unsigned TIMEOUT_CYC = CLK_FREQ * TIMEOUT_S;
    localparam int unsigned SCROLL_CYC  = CLK_FREQ * SCROLL_S;
    localparam int unsigned MAX_CYC     = max_u(TIMEOUT_CYC, SCROLL_CYC);
    localparam int unsigned TW          = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] SCROLL_LIMIT  = TW'(SCROLL_CYC - 1);

    mode_t            state;
    mode_t            next_state;
    sched_out_t       out_q;
    sched_out_t       out_d;
    logic [LED_W-1:0] scroll_q;
    logic [LED_W-1:0] scroll_d;

    logic             tmr_clear;
    logic             tmr_enable;
    logic             tmr_expired;
    logic [TW-1:0]    tmr_limit;

    // One shared counter: idle timeout in manual mode, scroll period in auto mode.
    assign tmr_enable = (state != SW);
    assign tmr_limit  = (state == STASH_MAN) ? TIMEOUT_LIMIT : SCROLL_LIMIT;

    interval_timer #(
        .W(TW)
    ) u_timer (
        .clk     (clk),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .limit   (tmr_limit),
        .expired (tmr_expired)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SW;
            out_q    <= OUT_RESET;
            scroll_q <= SCROLL_FIRST;
        end else begin
            state    <= next_state;
            out_q    <= out_d;
            scroll_q <= scroll_d;
        end
    end

    // Next state, next outputs and timer clear; toggle > split > trig > expiry.
    always_comb begin
        next_state        = state;
        scroll_d          = scroll_q;
        out_d             = OUT_RESET;
        out_d.sw_selected = 1'b0;
        out_d.led_left    = LED_OFF;
        out_d.stash_valid = sample;
        tmr_clear         = 1'b0;

        case (state)
            SW: begin
                if (toggle) begin
                    next_state = STASH_MAN;
                end else if (split) begin
                    out_d.ctl_split = 1'b1;
                end else if (trig) begin
                    out_d.ctl_trig = 1'b1;
                end
            end
            STASH_MAN: begin
                if (toggle) begin
                    next_state = SW;
                end else if (split) begin
                    next_state = STASH_AUTO;
                end else if (trig) begin
                    out_d.stash_next = 1'b1;
                    tmr_clear        = 1'b1;
                end else if (tmr_expired) begin
                    next_state = SW;
                end
            end
            STASH_AUTO: begin
                if (toggle) begin
                    next_state = SW;
                end else if (split || trig) begin
                    next_state = STASH_MAN;
                end else if (tmr_expired) begin
                    out_d.stash_next = 1'b1;
                    scroll_d         = rotl_led(scroll_q);
                end
            end
            default: begin
                next_state = SW;
            end
        endcase

        if (next_state == STASH_AUTO && state != STASH_AUTO) begin
            scroll_d = SCROLL_FIRST;
        end

        if (reset || state == SW || next_state != state) begin
            tmr_clear = 1'b1;
        end

        out_d.sw_selected = (next_state == SW);
        case (next_state)
            SW: begin
                out_d.led_left  = LED_ON;
                out_d.led_right = LED_OFF;
            end
            STASH_MAN: begin
                out_d.led_left  = LED_OFF;
                out_d.led_right = LED_ON;
            end
            default: begin
                out_d.led_left  = LED_OFF;
                out_d.led_right = scroll_d;
            end
        endcase
    end

    assign ctl_trig    = out_q.ctl_trig;
    assign ctl_split   = out_q.ctl_split;
    assign stash_next  = out_q.stash_next;
    assign stash_valid = out_q.stash_valid;
    assign sw_selected = out_q.sw_selected;
    assign led_left    = out_q.led_left;
    assign led_right   = out_q.led_right;

endmodule

// File: tb/tb_mode_scheduler.sv
// Directed bench for mode_scheduler with short timing parameters
// (10 cycles per second, 30-cycle idle timeout, 10-cycle scroll period).
module tb_mode_scheduler;

    localparam int unsigned CLK_FREQ  = 10;
    localparam int unsigned TIMEOUT_S = 3;
    localparam int unsigned SCROLL_S  = 1;

    // outs = {sw_selected, ctl_trig, ctl_split, stash_next, stash_valid, led_left, led_right}
    localparam logic [10:0] SW_Q  = 11'b1_0000_111_000;
    localparam logic [10:0] MAN_Q = 11'b0_0000_000_111;
    localparam logic [10:0] CT    = 11'h200;
    localparam logic [10:0] CS    = 11'h100;
    localparam logic [10:0] SN    = 11'h080;
    localparam logic [10:0] SV    = 11'h040;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic toggle = 1'b0;
    logic trig = 1'b0;
    logic split = 1'b0;
    logic sample = 1'b0;

    logic       ctl_trig;
    logic       ctl_split;
    logic       stash_next;
    logic       stash_valid;
    logic       sw_selected;
    logic [2:0] led_left;
    logic [2:0] led_right;
    logic [10:0] outs;

    int errors = 0;
    int checks = 0;

    mode_scheduler #(
        .CLK_FREQ  (CLK_FREQ),
        .TIMEOUT_S (TIMEOUT_S),
        .SCROLL_S  (SCROLL_S)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .toggle      (toggle),
        .trig        (trig),
        .split       (split),
        .sample      (sample),
        .ctl_trig    (ctl_trig),
        .ctl_split   (ctl_split),
        .stash_next  (stash_next),
        .stash_valid (stash_valid),
        .sw_selected (sw_selected),
        .led_left    (led_left),
        .led_right   (led_right)
    );

    always #5 clk = ~clk;

    assign outs = {sw_selected, ctl_trig, ctl_split, stash_next, stash_valid, led_left, led_right};

    function automatic logic [10:0] auto_q(input logic [2:0] idx);
        return {8'b0, idx};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (outs !== SW_Q) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", outs, SW_Q);
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) step();
        checks++;
        if (outs !== SW_Q) begin
            errors++;
            $display("FAIL idle_sw: got %b expected %b", outs, SW_Q);
        end
    endtask

    task automatic test_sw_pulses();
        trig = 1'b1; step(); trig = 1'b0;
        checks++;
        if (outs !== (SW_Q | CT)) begin
            errors++;
            $display("FAIL sw_trig: got %b expected %b", outs, SW_Q | CT);
        end
        step();
        checks++;
        if (outs !== SW_Q) begin
            errors++;
            $display("FAIL sw_trig_single: got %b expected %b", outs, SW_Q);
        end
        split = 1'b1; step(); split = 1'b0;
        checks++;
        if (outs !== (SW_Q | CS)) begin
            errors++;
            $display("FAIL sw_split: got %b expected %b", outs, SW_Q | CS);
        end
        split = 1'b1; trig = 1'b1; step(); split = 1'b0; trig = 1'b0;
        checks++;
        if (outs !== (SW_Q | CS)) begin
            errors++;
            $display("FAIL sw_split_over_trig: got %b expected %b", outs, SW_Q | CS);
        end
    endtask

    task automatic test_man_timeout();
        toggle = 1'b1; step(); toggle = 1'b0;
        checks++;
        if (outs !== MAN_Q) begin
            errors++;
            $display("FAIL enter_man: got %b expected %b", outs, MAN_Q);
        end
        for (int k = 0; k < 3; k++) step();
        trig = 1'b1; step(); trig = 1'b0;
        checks++;
        if (outs !== (MAN_Q | SN)) begin
            errors++;
            $display("FAIL man_trig: got %b expected %b", outs, MAN_Q | SN);
        end
        for (int k = 1; k < 30; k++) begin
            step();
            checks++;
            if (outs !== MAN_Q) begin
                errors++;
                $display("FAIL man_hold cycle %0d: got %b expected %b", k, outs, MAN_Q);
            end
        end
        step();
        checks++;
        if (outs !== SW_Q) begin
            errors++;
            $display("FAIL man_timeout: got %b expected %b", outs, SW_Q);
        end
    endtask

    task automatic test_auto_scroll();
        logic [2:0]  idx;
        logic [10:0] exp;
        toggle = 1'b1; step(); toggle = 1'b0;
        split = 1'b1; step(); split = 1'b0;
        checks++;
        if (outs !== auto_q(3'b001)) begin
            errors++;
            $display("FAIL auto_entry: got %b expected %b", outs, auto_q(3'b001));
        end
        for (int k = 1; k <= 39; k++) begin
            step();
            if (k < 10)      idx = 3'b001;
            else if (k < 20) idx = 3'b010;
            else if (k < 30) idx = 3'b100;
            else             idx = 3'b001;
            exp = auto_q(idx) | ((k % 10 == 0) ? SN : 11'h000);
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL auto_scroll entry+%0d: got %b expected %b", k, outs, exp);
            end
        end
        // trig lands on the same edge as the scroll expiry: it must win
        trig = 1'b1; step(); trig = 1'b0;
        checks++;
        if (outs !== MAN_Q) begin
            errors++;
            $display("FAIL auto_trig_on_expiry: got %b expected %b", outs, MAN_Q);
        end
        split = 1'b1; step(); split = 1'b0;
        for (int k = 0; k < 14; k++) step();
        trig = 1'b1; step(); trig = 1'b0;
        checks++;
        if (outs !== MAN_Q) begin
            errors++;
            $display("FAIL auto_trig_15: got %b expected %b", outs, MAN_Q);
        end
        step();
        checks++;
        if (outs !== MAN_Q) begin
            errors++;
            $display("FAIL auto_trig_16: got %b expected %b", outs, MAN_Q);
        end
        toggle = 1'b1; step(); toggle = 1'b0;
        checks++;
        if (outs !== SW_Q) begin
            errors++;
            $display("FAIL man_toggle_sw: got %b expected %b", outs, SW_Q);
        end
    endtask

    task automatic test_same_cycle();
        toggle = 1'b1; trig = 1'b1; step(); toggle = 1'b0; trig = 1'b0;
        checks++;
        if (outs !== MAN_Q) begin
            errors++;
            $display("FAIL toggle_over_trig_sw: got %b expected %b", outs, MAN_Q);
        end
        split = 1'b1; trig = 1'b1; step(); split = 1'b0; trig = 1'b0;
        checks++;
        if (outs !== auto_q(3'b001)) begin
            errors++;
            $display("FAIL split_over_trig_man: got %b expected %b", outs, auto_q(3'b001));
        end
        toggle = 1'b1; split = 1'b1; step(); toggle = 1'b0; split = 1'b0;
        checks++;
        if (outs !== SW_Q) begin
            errors++;
            $display("FAIL toggle_over_split_auto: got %b expected %b", outs, SW_Q);
        end
    endtask

    task automatic test_sample();
        sample = 1'b1; step(); sample = 1'b0;
        checks++;
        if (outs !== (SW_Q | SV)) begin
            errors++;
            $display("FAIL sample_sw: got %b expected %b", outs, SW_Q | SV);
        end
        step();
        checks++;
        if (outs !== SW_Q) begin
            errors++;
            $display("FAIL sample_sw_single: got %b expected %b", outs, SW_Q);
        end
        toggle = 1'b1; step(); toggle = 1'b0;
        trig = 1'b1; step(); trig = 1'b0;
        for (int k = 0; k < 5; k++) step();
        sample = 1'b1; step(); sample = 1'b0;
        checks++;
        if (outs !== (MAN_Q | SV)) begin
            errors++;
            $display("FAIL sample_man: got %b expected %b", outs, MAN_Q | SV);
        end
        for (int k = 7; k < 30; k++) step();
        checks++;
        if (outs !== MAN_Q) begin
            errors++;
            $display("FAIL sample_man_hold: got %b expected %b", outs, MAN_Q);
        end
        step();
        checks++;
        if (outs !== SW_Q) begin
            errors++;
            $display("FAIL sample_man_timeout: got %b expected %b", outs, SW_Q);
        end
        toggle = 1'b1; step(); toggle = 1'b0;
        split = 1'b1; step(); split = 1'b0;
        for (int k = 0; k < 4; k++) step();
        sample = 1'b1; step(); sample = 1'b0;
        checks++;
        if (outs !== (auto_q(3'b001) | SV)) begin
            errors++;
            $display("FAIL sample_auto: got %b expected %b", outs, auto_q(3'b001) | SV);
        end
        for (int k = 6; k < 10; k++) step();
        checks++;
        if (outs !== auto_q(3'b001)) begin
            errors++;
            $display("FAIL sample_auto_hold: got %b expected %b", outs, auto_q(3'b001));
        end
        step();
        checks++;
        if (outs !== (auto_q(3'b010) | SN)) begin
            errors++;
            $display("FAIL sample_auto_scroll: got %b expected %b", outs, auto_q(3'b010) | SN);
        end
    endtask

    task automatic test_reset_mid();
        trig = 1'b1; step(); trig = 1'b0;
        split = 1'b1; step(); split = 1'b0;
        for (int k = 0; k < 6; k++) step();
        reset = 1'b1; step(); reset = 1'b0;
        checks++;
        if (outs !== SW_Q) begin
            errors++;
            $display("FAIL reset_mid_auto: got %b expected %b", outs, SW_Q);
        end
        for (int k = 8; k <= 10; k++) begin
            step();
            checks++;
            if (outs !== SW_Q) begin
                errors++;
                $display("FAIL after_reset entry+%0d: got %b expected %b", k, outs, SW_Q);
            end
        end
        toggle = 1'b1; step(); toggle = 1'b0;
        for (int k = 0; k < 10; k++) step();
        reset = 1'b1; step(); reset = 1'b0;
        checks++;
        if (outs !== SW_Q) begin
            errors++;
            $display("FAIL reset_mid_man: got %b expected %b", outs, SW_Q);
        end
    endtask

    initial begin
        test_reset();
        test_sw_pulses();
        test_man_timeout();
        test_auto_scroll();
        test_same_cycle();
        test_sample();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
